// File: rtl/conf_shift_driver_if.sv
// Host request/status lines and MONOPIX configuration pad signals for conf_shift_driver.
// master = the driver itself, slave = whoever requests transactions and models the chip side.
interface conf_shift_driver_if #(
  parameter int CONF_WIDTH = 16
);
  logic                  start;
  logic [CONF_WIDTH-1:0] conf_data;
  logic                  def_req;
  logic                  so_conf;
  logic                  clk_conf;
  logic                  si_conf;
  logic                  ld_conf;
  logic                  def_conf;
  logic                  busy;
  logic                  done;
  logic [CONF_WIDTH-1:0] readback;
  logic                  mismatch;

  modport master (
    input  start, conf_data, def_req, so_conf,
    output clk_conf, si_conf, ld_conf, def_conf, busy, done, readback, mismatch
  );

  modport slave (
    output start, conf_data, def_req, so_conf,
    input  clk_conf, si_conf, ld_conf, def_conf, busy, done, readback, mismatch
  );
endinterface

// File: rtl/conf_shift_driver.sv
// Serial configuration driver: shifts a word LSB-first with a divided CLK_CONF, then GAP/LOAD/POST.
// Optional macro CONF_READBACK_EN enables SO_CONF capture into readback and the mismatch flag.
module conf_shift_driver #(
  parameter int CONF_WIDTH = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic clk,
  input  logic rst_n,
  conf_shift_driver_if.master bus
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int CW = $clog2(CONF_WIDTH + 5);
  localparam logic [HW-1:0] H_LAST  = HW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CP_GAP  = CW'(CONF_WIDTH);
  localparam logic [CW-1:0] CP_LOAD = CW'(CONF_WIDTH + 1);
  localparam logic [CW-1:0] CP_POST = CW'(CONF_WIDTH + 2);
  localparam logic [CW-1:0] CP_END  = CW'(CONF_WIDTH + 4);

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, LOAD, POST} state_t;

  state_t                state;
  logic                  arm;
  logic [HW-1:0]         hcnt;
  logic                  phase;
  logic [CW-1:0]         cp;
  logic [CW-1:0]         cp_next;
  logic [CONF_WIDTH-1:0] shreg;
  logic                  clk_conf, si_conf, ld_conf, def_conf, busy, done;
  logic                  rise_tick, cp_end_tick, last_tick;

  // arm marks the one cycle between the accepted START and the first CP edge.
  assign cp_next     = cp + CW'(1);
  assign rise_tick   = (state != IDLE) && !arm && !phase && (hcnt == H_LAST);
  assign cp_end_tick = (state != IDLE) && !arm &&  phase && (hcnt == H_LAST);
  assign last_tick   = cp_end_tick && (cp_next == CP_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      arm      <= 1'b0;
      hcnt     <= '0;
      phase    <= 1'b0;
      cp       <= '0;
      shreg    <= '0;
      clk_conf <= 1'b0;
      si_conf  <= 1'b0;
      ld_conf  <= 1'b0;
      def_conf <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          hcnt     <= '0;
          phase    <= 1'b0;
          cp       <= '0;
          clk_conf <= 1'b0;
          si_conf  <= 1'b0;
          ld_conf  <= 1'b0;
          if (bus.start) begin
            shreg <= bus.conf_data;
            arm   <= 1'b1;
            busy  <= 1'b1;
            state <= SHIFT;
          end else if (bus.def_req) begin
            def_conf <= 1'b1;
          end
        end
        default: begin
          if (arm) begin
            arm      <= 1'b0;
            hcnt     <= '0;
            phase    <= 1'b0;
            cp       <= '0;
            clk_conf <= 1'b0;
            si_conf  <= shreg[0];
            shreg    <= shreg >> 1;
          end else if (hcnt != H_LAST) begin
            hcnt <= hcnt + HW'(1);
          end else if (!phase) begin
            hcnt     <= '0;
            phase    <= 1'b1;
            clk_conf <= 1'b1;
          end else begin
            // End of a CP: SI/LD only ever change here, on the falling CLK_CONF edge.
            hcnt     <= '0;
            phase    <= 1'b0;
            clk_conf <= 1'b0;
            cp       <= cp_next;
            if (cp_next < CP_GAP) begin
              si_conf <= shreg[0];
              shreg   <= shreg >> 1;
            end else if (cp_next == CP_GAP) begin
              state   <= GAP;
              si_conf <= 1'b0;
            end else if (cp_next == CP_LOAD) begin
              state   <= LOAD;
              ld_conf <= 1'b1;
            end else if (cp_next == CP_POST) begin
              state   <= POST;
              ld_conf <= 1'b0;
            end else if (cp_next == CP_END) begin
              state    <= IDLE;
              cp       <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              def_conf <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.clk_conf = clk_conf;
  assign bus.si_conf  = si_conf;
  assign bus.ld_conf  = ld_conf;
  assign bus.def_conf = def_conf;
  assign bus.busy     = busy;
  assign bus.done     = done;

`ifdef CONF_READBACK_EN
  logic [CONF_WIDTH-1:0] latched, readback, rb_shift;
  logic                  mismatch;

  // Samples enter at the MSB so that after CONF_WIDTH rises sample k sits at bit k.
  always_comb begin
    rb_shift             = readback >> 1;
    rb_shift[CONF_WIDTH-1] = bus.so_conf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latched  <= '0;
      readback <= '0;
      mismatch <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      latched  <= bus.conf_data;
      readback <= '0;
      mismatch <= 1'b0;
    end else if (state == SHIFT && rise_tick) begin
      readback <= rb_shift;
    end else if (last_tick) begin
      mismatch <= (readback != latched);
    end
  end

  assign bus.readback = readback;
  assign bus.mismatch = mismatch;
`else
  logic unused_readback_inputs;
  assign unused_readback_inputs = bus.so_conf ^ rise_tick ^ last_tick;
  assign bus.readback = '0;
  assign bus.mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_conf_shift_driver.sv
// Directed self-checking bench for conf_shift_driver (CONF_WIDTH=16, CLK_DIV=2, CP = 4 cycles).
module tb_conf_shift_driver;
  logic clk = 1'b0;
  logic rst_n;
  logic so_loop;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  conf_shift_driver_if #(.CONF_WIDTH(16)) bus ();

  conf_shift_driver #(.CONF_WIDTH(16), .CLK_DIV(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Chip model: either echoes SI_CONF back or holds SO_CONF low.
  assign bus.so_conf = so_loop ? bus.si_conf : 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs one transaction and records the waveform relative to the START edge (rel 0).
  task automatic run_txn(input logic [15:0] data, input logic [15:0] data2, input int restart_at,
                         input logic with_def,
                         output logic [15:0] si_bits, output int rises, output int clk_high,
                         output int ld_cycles, output int ld_first, output int def_fall,
                         output int done_at, output int done_count, output logic busy_first,
                         output logic def_at5);
    logic prev_clk, prev_def;
    si_bits = '0; rises = 0; clk_high = 0; ld_cycles = 0; ld_first = -1;
    def_fall = -1; done_at = -1; done_count = 0; busy_first = 1'b0; def_at5 = 1'bx;
    @(negedge clk);
    bus.conf_data = data;
    bus.start     = 1'b1;
    bus.def_req   = with_def;
    prev_clk = bus.clk_conf;
    prev_def = bus.def_conf;
    @(negedge clk);
    bus.def_req = 1'b0;
    for (int rel = 0; rel < 95; rel++) begin
      if (rel == 0) busy_first = bus.busy;
      if (rel == 5) def_at5 = bus.def_conf;
      if (!prev_clk && bus.clk_conf) begin
        if (rises < 16) si_bits[rises] = bus.si_conf;
        rises++;
      end
      if (bus.clk_conf) clk_high++;
      if (bus.ld_conf) begin
        ld_cycles++;
        if (ld_first < 0) ld_first = rel;
      end
      if (prev_def && !bus.def_conf && def_fall < 0) def_fall = rel;
      if (bus.done) begin
        done_count++;
        if (done_at < 0) done_at = rel;
      end
      prev_clk = bus.clk_conf;
      prev_def = bus.def_conf;
      bus.start = (rel == restart_at - 1);
      if (bus.start) bus.conf_data = data2;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    int done_seen = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.def_req = 1'b0; bus.conf_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    checks++; if (bus.def_conf !== 1'b1) begin errors++; $display("[TB] FAIL reset_def_conf: got %b want 1", bus.def_conf); end
    checks++; if (bus.clk_conf !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_conf: got %b want 0", bus.clk_conf); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.si_conf !== 1'b0 || bus.ld_conf !== 1'b0) begin errors++; $display("[TB] FAIL reset_si_ld: got si=%b ld=%b want 0 0", bus.si_conf, bus.ld_conf); end
    checks++; if (done_seen != 0) begin errors++; $display("[TB] FAIL reset_no_done: got %0d pulses want 0", done_seen); end
    checks++; if (bus.readback !== 16'h0000 || bus.mismatch !== 1'b0) begin errors++; $display("[TB] FAIL reset_readback: got %h/%b want 0000/0", bus.readback, bus.mismatch); end
  endtask

  task automatic test_shift_pattern();
    logic [15:0] si; int rises, clk_high, ld_cycles, ld_first, def_fall, done_at, done_count;
    logic busy_first, def_at5;
    run_txn(16'hA5C3, 16'h0000, -1, 1'b0, si, rises, clk_high, ld_cycles, ld_first, def_fall,
            done_at, done_count, busy_first, def_at5);
    checks++; if (si !== 16'hA5C3) begin errors++; $display("[TB] FAIL shift_si_bits: got %h want a5c3", si); end
    checks++; if (rises != 20) begin errors++; $display("[TB] FAIL shift_clk_rises: got %0d want 20", rises); end
    checks++; if (clk_high != 40) begin errors++; $display("[TB] FAIL shift_clk_high: got %0d want 40", clk_high); end
    checks++; if (ld_cycles != 4 || ld_first != 69) begin errors++; $display("[TB] FAIL shift_ld: got %0d cycles from %0d want 4 from 69", ld_cycles, ld_first); end
    checks++; if (def_fall != 81) begin errors++; $display("[TB] FAIL shift_def_fall: got %0d want 81", def_fall); end
    checks++; if (done_at != 81 || done_count != 1) begin errors++; $display("[TB] FAIL shift_done: got at %0d count %0d want at 81 count 1", done_at, done_count); end
    checks++; if (busy_first !== 1'b1) begin errors++; $display("[TB] FAIL shift_busy_start: got %b want 1", busy_first); end
    checks++; if (bus.busy !== 1'b0 || bus.clk_conf !== 1'b0 || bus.def_conf !== 1'b0) begin errors++; $display("[TB] FAIL shift_end_state: got busy=%b clk=%b def=%b want 0 0 0", bus.busy, bus.clk_conf, bus.def_conf); end
  endtask

  task automatic test_busy_reject();
    logic [15:0] si; int rises, clk_high, ld_cycles, ld_first, def_fall, done_at, done_count;
    logic busy_first, def_at5;
    run_txn(16'hA5C3, 16'h1234, 10, 1'b0, si, rises, clk_high, ld_cycles, ld_first, def_fall,
            done_at, done_count, busy_first, def_at5);
    checks++; if (si !== 16'hA5C3) begin errors++; $display("[TB] FAIL busy_si_bits: got %h want a5c3", si); end
    checks++; if (rises != 20 || ld_first != 69) begin errors++; $display("[TB] FAIL busy_waveform: got rises %0d ld_first %0d want 20 69", rises, ld_first); end
    checks++; if (done_at != 81 || done_count != 1) begin errors++; $display("[TB] FAIL busy_done: got at %0d count %0d want at 81 count 1", done_at, done_count); end
  endtask

  task automatic test_default_reentry();
    logic [15:0] si; int rises, clk_high, ld_cycles, ld_first, def_fall, done_at, done_count;
    logic busy_first, def_at5;
    checks++; if (bus.def_conf !== 1'b0) begin errors++; $display("[TB] FAIL def_after_done: got %b want 0", bus.def_conf); end
    bus.def_req = 1'b1;
    @(negedge clk);
    bus.def_req = 1'b0;
    checks++; if (bus.def_conf !== 1'b1) begin errors++; $display("[TB] FAIL def_req_pulse: got %b want 1", bus.def_conf); end
    run_txn(16'h00FF, 16'h0000, -1, 1'b1, si, rises, clk_high, ld_cycles, ld_first, def_fall,
            done_at, done_count, busy_first, def_at5);
    checks++; if (done_at != 81 || si !== 16'h00FF) begin errors++; $display("[TB] FAIL def_start_runs: got done %0d si %h want 81 00ff", done_at, si); end
    checks++; if (def_at5 !== 1'b1 || def_fall != 81) begin errors++; $display("[TB] FAIL def_held_high: got at5 %b fall %0d want 1 81", def_at5, def_fall); end
    run_txn(16'h8001, 16'h0000, -1, 1'b1, si, rises, clk_high, ld_cycles, ld_first, def_fall,
            done_at, done_count, busy_first, def_at5);
    checks++; if (def_at5 !== 1'b0 || done_at != 81) begin errors++; $display("[TB] FAIL def_start_wins: got at5 %b done %0d want 0 81", def_at5, done_at); end
  endtask

  task automatic test_reset_mid_shift();
    logic [15:0] si; int rises, clk_high, ld_cycles, ld_first, def_fall, done_at, done_count;
    logic busy_first, def_at5;
    @(negedge clk);
    bus.conf_data = 16'hFFFF;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (23) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.clk_conf !== 1'b0 || bus.si_conf !== 1'b0 || bus.ld_conf !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("[TB] FAIL midrst_outputs: got busy=%b clk=%b si=%b ld=%b done=%b want all 0", bus.busy, bus.clk_conf, bus.si_conf, bus.ld_conf, bus.done); end
    checks++; if (bus.def_conf !== 1'b1) begin errors++; $display("[TB] FAIL midrst_def_conf: got %b want 1", bus.def_conf); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(16'h3C0F, 16'h0000, -1, 1'b0, si, rises, clk_high, ld_cycles, ld_first, def_fall,
            done_at, done_count, busy_first, def_at5);
    checks++; if (si !== 16'h3C0F || rises != 20) begin errors++; $display("[TB] FAIL midrst_restart_si: got %h rises %0d want 3c0f 20", si, rises); end
    checks++; if (done_at != 81 || def_fall != 81 || ld_cycles != 4) begin errors++; $display("[TB] FAIL midrst_restart_timing: got done %0d def_fall %0d ld %0d want 81 81 4", done_at, def_fall, ld_cycles); end
  endtask

  task automatic test_readback();
    logic [15:0] si; int rises, clk_high, ld_cycles, ld_first, def_fall, done_at, done_count;
    logic busy_first, def_at5;
    so_loop = 1'b1;
    run_txn(16'hA5C3, 16'h0000, -1, 1'b0, si, rises, clk_high, ld_cycles, ld_first, def_fall,
            done_at, done_count, busy_first, def_at5);
`ifdef CONF_READBACK_EN
    checks++; if (bus.readback !== 16'hA5C3 || bus.mismatch !== 1'b0) begin errors++; $display("[TB] FAIL readback_loop: got %h/%b want a5c3/0", bus.readback, bus.mismatch); end
    so_loop = 1'b0;
    run_txn(16'hA5C3, 16'h0000, -1, 1'b0, si, rises, clk_high, ld_cycles, ld_first, def_fall,
            done_at, done_count, busy_first, def_at5);
    checks++; if (bus.readback !== 16'h0000 || bus.mismatch !== 1'b1) begin errors++; $display("[TB] FAIL readback_zero: got %h/%b want 0000/1", bus.readback, bus.mismatch); end
`else
    checks++; if (bus.readback !== 16'h0000 || bus.mismatch !== 1'b0) begin errors++; $display("[TB] FAIL readback_tied: got %h/%b want 0000/0", bus.readback, bus.mismatch); end
`endif
    so_loop = 1'b1;
  endtask

  initial begin
    so_loop = 1'b1;
    test_reset();
    test_shift_pattern();
    test_busy_reject();
    test_default_reentry();
    test_reset_mid_shift();
    test_readback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
